alu_mc: RTL and testbench

Parametrised, registered successor to the combinational execute-stage ALU. It takes one micro-op per handshake over a valid/ready interface and registers the result. Single-cycle ops complete in 1 cycle, and the optional multiply ops run on an iterative shift-add engine. It sits in the execute stage between issue and writeback, and a writeback stall back-pressures issue through `alu_in_ready`.

---
 rtl/alu_mc.sv | 203 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: registered execute-stage ALU with valid/ready handshake on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (MUL/MULH/MULHU).
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_flush,
    input  logic             alu_in_valid,
    output logic             alu_in_ready,
    input  logic [3:0]       alu_control,
    input  logic [RD_W-1:0]  alu_rd_in,
    input  logic [WIDTH-1:0] alu_sr0,
    input  logic [WIDTH-1:0] alu_sr1,
    output logic             alu_out_valid,
    input  logic             alu_out_ready,
    output logic [RD_W-1:0]  alu_rd_out,
    output logic [WIDTH-1:0] alu_result
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] CTRL_ALU_ADD  = 4'd0;
    localparam logic [3:0] CTRL_ALU_SUB  = 4'd1;
    localparam logic [3:0] CTRL_ALU_SLT  = 4'd2;
    localparam logic [3:0] CTRL_ALU_SLTU = 4'd3;
    localparam logic [3:0] CTRL_ALU_AND  = 4'd4;
    localparam logic [3:0] CTRL_ALU_OR   = 4'd5;
    localparam logic [3:0] CTRL_ALU_NOR  = 4'd6;
    localparam logic [3:0] CTRL_ALU_XOR  = 4'd7;
    localparam logic [3:0] CTRL_ALU_SLL  = 4'd8;
    localparam logic [3:0] CTRL_ALU_SRL  = 4'd9;
    localparam logic [3:0] CTRL_ALU_SRA  = 4'd10;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [RD_W-1:0]  rd_q, rd_d;

    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [RD_W-1:0]  mul_rd;
    logic [WIDTH-1:0] single_res;
    logic [SHW-1:0]   shamt;

    assign alu_in_ready  = (state_q == StIdle) && (!out_valid_q || alu_out_ready) && !alu_flush;
    assign accept        = alu_in_valid && alu_in_ready;
    assign alu_out_valid = out_valid_q;
    assign alu_result    = result_q;
    assign alu_rd_out    = rd_q;
    assign shamt         = alu_sr0[SHW-1:0];

    always_comb begin
        single_res = '0;
        case (alu_control)
            CTRL_ALU_ADD:  single_res = alu_sr0 + alu_sr1;
            CTRL_ALU_SUB:  single_res = alu_sr0 - alu_sr1;
            CTRL_ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(alu_sr0) < $signed(alu_sr1)};
            CTRL_ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, alu_sr0 < alu_sr1};
            CTRL_ALU_AND:  single_res = alu_sr0 & alu_sr1;
            CTRL_ALU_OR:   single_res = alu_sr0 | alu_sr1;
            CTRL_ALU_NOR:  single_res = ~(alu_sr0 | alu_sr1);
            CTRL_ALU_XOR:  single_res = alu_sr0 ^ alu_sr1;
            CTRL_ALU_SLL:  single_res = alu_sr1 << shamt;
            CTRL_ALU_SRL:  single_res = alu_sr1 >> shamt;
            CTRL_ALU_SRA:  single_res = $signed(alu_sr1) >>> shamt;
            default:       single_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] CTRL_ALU_MUL   = 4'd11;
    localparam logic [3:0] CTRL_ALU_MULH  = 4'd12;
    localparam logic [3:0] CTRL_ALU_MULHU = 4'd13;

    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               hi_q, hi_d;
    logic [RD_W-1:0]    mul_rd_q, mul_rd_d;
    logic               is_mulh;
    logic [WIDTH-1:0]   sr0_mag, sr1_mag;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_step, prod;

    assign is_mul   = (alu_control == CTRL_ALU_MUL) || (alu_control == CTRL_ALU_MULH) ||
                      (alu_control == CTRL_ALU_MULHU);
    assign is_mulh  = (alu_control == CTRL_ALU_MULH);
    assign sr0_mag  = (is_mulh && alu_sr0[WIDTH-1]) ? -alu_sr0 : alu_sr0;
    assign sr1_mag  = (is_mulh && alu_sr1[WIDTH-1]) ? -alu_sr1 : alu_sr1;

    // Multiplier lives in acc low half; each step adds mcand to the high half and shifts right.
    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {step_sum, acc_q[WIDTH-1:1]};
    assign prod     = neg_q ? -acc_step : acc_step;
    assign mul_res  = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    assign mul_done = (cnt_q == '0);
    assign mul_rd   = mul_rd_q;

    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        mul_rd_d = mul_rd_q;
        if (accept && is_mul) begin
            cnt_d    = SHW'(WIDTH - 1);
            mcand_d  = sr0_mag;
            acc_d    = {{WIDTH{1'b0}}, sr1_mag};
            neg_d    = is_mulh && (alu_sr0[WIDTH-1] ^ alu_sr1[WIDTH-1]);
            hi_d     = (alu_control != CTRL_ALU_MUL);
            mul_rd_d = alu_rd_in;
        end else if (state_q == StBusy) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            mul_rd_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            mul_rd_q <= mul_rd_d;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_rd   = '0;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        if (out_valid_q && alu_out_ready) begin
            out_valid_d = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = StBusy;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = single_res;
                        rd_d        = alu_rd_in;
                    end
                end
            end
            StBusy: begin
                if (mul_done) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    result_d    = mul_res;
                    rd_d        = mul_rd;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush beats a coinciding completion; result/rd are left as they were.
        if (alu_flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            result_d    = result_q;
            rd_d        = rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc: a WIDTH=32 instance and a WIDTH=8 instance.
module tb_alu_mc;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLT = 4'd2, SLTU = 4'd3;
    localparam logic [3:0] AND_ = 4'd4, OR_ = 4'd5, NOR_ = 4'd6, XOR_ = 4'd7;
    localparam logic [3:0] SLL = 4'd8, SRL = 4'd9, SRA = 4'd10;
    localparam logic [3:0] MUL = 4'd11, MULH = 4'd12, MULHU = 4'd13, UNDEF = 4'd15;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [3:0]  ctrl;
    logic [4:0]  rd_in;
    logic [31:0] sr0, sr1;
    logic        in_ready, out_valid;
    logic [4:0]  rd_out;
    logic [31:0] res;

    logic        e_valid;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic [7:0]  e_sr0, e_sr1;
    logic        e_in_ready, e_out_valid;
    logic [4:0]  e_rd_out;
    logic [7:0]  e_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .RD_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .alu_flush(flush), .alu_in_valid(in_valid),
        .alu_in_ready(in_ready), .alu_control(ctrl), .alu_rd_in(rd_in),
        .alu_sr0(sr0), .alu_sr1(sr1), .alu_out_valid(out_valid),
        .alu_out_ready(out_ready), .alu_rd_out(rd_out), .alu_result(res)
    );

    alu_mc #(.WIDTH(8), .RD_W(5)) u_dut8 (
        .clk(clk), .rst(rst), .alu_flush(1'b0), .alu_in_valid(e_valid),
        .alu_in_ready(e_in_ready), .alu_control(e_ctrl), .alu_rd_in(e_rd),
        .alu_sr0(e_sr0), .alu_sr1(e_sr1), .alu_out_valid(e_out_valid),
        .alu_out_ready(1'b1), .alu_rd_out(e_rd_out), .alu_result(e_res)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        in_valid = 1'b1;
        ctrl     = c;
        sr0      = a;
        sr1      = b;
        rd_in    = r;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        e_valid  = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", res); end
        total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", rd_out); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        total++; if (e_out_valid !== 1'b0 || e_res !== 8'h0 || e_in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_w8 got=%b/%h/%b want=0/00/1", e_out_valid, e_res, e_in_ready);
        end
    endtask

    task automatic test_sub_slt_sra();
        logic [3:0]  ops [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [31:0] exp [3];
        ops = '{SUB, SLT, SRA};
        a   = '{32'd5, 32'h8000_0000, 32'd4};
        b   = '{32'd7, 32'd1, 32'h8000_0000};
        exp = '{32'hFFFF_FFFE, 32'd1, 32'hF800_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], a[i], b[i], 5'(3 + i));
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || res !== exp[i] || rd_out !== 5'(3 + i)) begin
                bad++;
                $display("FAIL b2b[%0d] got v=%b r=%h rd=%0d want v=1 r=%h rd=%0d",
                         i, out_valid, res, rd_out, exp[i], 3 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_retire got=%b want=0", out_valid); end
    endtask

    task automatic test_op_table();
        logic [3:0]  ops [10];
        logic [31:0] a [10];
        logic [31:0] b [10];
        logic [31:0] exp [10];
        ops = '{ADD, SLTU, SLT, AND_, OR_, NOR_, XOR_, SLL, SRL, UNDEF};
        a   = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                32'hF0F0_F0F0, 32'd4, 32'd36, 32'd5};
        b   = '{32'd2, 32'h8000_0000, 32'h8000_0000, 32'hFF00_FF00, 32'hFF00_FF00,
                32'hFF00_FF00, 32'hFF00_FF00, 32'h8000_0001, 32'h8000_0000, 32'd7};
        exp = '{32'd1, 32'd1, 32'd0, 32'hF000_F000, 32'hFFF0_FFF0, 32'h000F_000F,
                32'h0FF0_0FF0, 32'h0000_0010, 32'h0800_0000, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], a[i], b[i], 5'(10 + i));
            tick();
            total++; if (out_valid !== 1'b1 || res !== exp[i] || rd_out !== 5'(10 + i)) begin
                bad++;
                $display("FAIL op[%0d] got v=%b r=%h rd=%0d want v=1 r=%h rd=%0d",
                         i, out_valid, res, rd_out, exp[i], 10 + i);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b1;
        issue(ADD, 32'd1, 32'd2, 5'd1);
        tick();
        total++; if (out_valid !== 1'b1 || res !== 32'd3) begin bad++; $display("FAIL bp_first got v=%b r=%h want v=1 r=3", out_valid, res); end
        out_ready = 1'b0;
        issue(ADD, 32'd4, 32'd4, 5'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (out_valid !== 1'b1 || res !== 32'd3 || rd_out !== 5'd1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got v=%b r=%h rd=%0d rdy=%b want v=1 r=3 rd=1 rdy=0",
                         i, out_valid, res, rd_out, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || res !== 32'd8 || rd_out !== 5'd2) begin
            bad++; $display("FAIL bp_swap got v=%b r=%h rd=%0d want v=1 r=8 rd=2", out_valid, res, rd_out);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        issue(ADD, 32'd9, 32'd1, 5'd7);
        tick();
        total++; if (out_valid !== 1'b1 || res !== 32'd10) begin bad++; $display("FAIL fl_load got v=%b r=%h want v=1 r=a", out_valid, res); end
        flush = 1'b1;
        out_ready = 1'b1;
        issue(ADD, 32'd2, 32'd2, 5'd8);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b want=0", in_ready); end
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || res !== 32'd10 || rd_out !== 5'd7) begin
            bad++; $display("FAIL fl_drop got v=%b r=%h rd=%0d want v=0 r=a rd=7", out_valid, res, rd_out);
        end
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_after_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || res !== 32'd4 || rd_out !== 5'd8) begin
            bad++; $display("FAIL fl_next got v=%b r=%h rd=%0d want v=1 r=4 rd=8", out_valid, res, rd_out);
        end
        tick();
    endtask

`ifdef ALU_MUL_EN
    task automatic run_mul(input logic [3:0] c, input logic [31:0] want, input logic [4:0] r);
        out_ready = 1'b1;
        issue(c, 32'hFFFF_FFFF, 32'h0000_0002, r);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_accept op=%0d got=%b want=1", c, in_ready); end
        tick();
        in_valid = 1'b0;
        for (int p = 0; p < 32; p++) begin
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad++; $display("FAIL mul_busy op=%0d p=%0d got v=%b rdy=%b want 0/0", c, p, out_valid, in_ready);
            end
            tick();
        end
        total++; if (out_valid !== 1'b1 || res !== want || rd_out !== r) begin
            bad++; $display("FAIL mul_result op=%0d got v=%b r=%h rd=%0d want v=1 r=%h rd=%0d",
                            c, out_valid, res, rd_out, want, r);
        end
        tick();
    endtask

    task automatic test_multiply();
        run_mul(MULH, 32'hFFFF_FFFF, 5'd20);
        run_mul(MULHU, 32'h0000_0001, 5'd21);
        run_mul(MUL, 32'hFFFF_FFFE, 5'd22);
    endtask

    task automatic test_flush_mul();
        out_ready = 1'b1;
        issue(MUL, 32'd3, 32'd5, 5'd11);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        issue(ADD, 32'd6, 32'd1, 5'd9);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flm_ready got=%b want=0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flm_idle got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || res !== 32'd7 || rd_out !== 5'd9) begin
            bad++; $display("FAIL flm_next got v=%b r=%h rd=%0d want v=1 r=7 rd=9", out_valid, res, rd_out);
        end
        issue(MUL, 32'd3, 32'd5, 5'd12);
        tick();
        in_valid = 1'b0;
        for (int p = 0; p < 31; p++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || res !== 32'd7 || rd_out !== 5'd9) begin
            bad++; $display("FAIL flm_done got v=%b r=%h rd=%0d want v=0 r=7 rd=9", out_valid, res, rd_out);
        end
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flm_late got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask
`else
    task automatic test_mul_disabled();
        out_ready = 1'b1;
        issue(MULH, 32'hFFFF_FFFF, 32'h0000_0002, 5'd13);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || res !== 32'd0 || rd_out !== 5'd13) begin
            bad++; $display("FAIL nomul got v=%b r=%h rd=%0d want v=1 r=0 rd=13", out_valid, res, rd_out);
        end
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nomul_ready got=%b want=1", in_ready); end
        tick();
    endtask
`endif

    task automatic test_width8();
        e_valid = 1'b1;
        e_ctrl  = SLL;
        e_sr0   = 8'd9;
        e_sr1   = 8'h81;
        e_rd    = 5'd3;
        tick();
        total++; if (e_out_valid !== 1'b1 || e_res !== 8'h02 || e_rd_out !== 5'd3) begin
            bad++; $display("FAIL w8_sll got v=%b r=%h rd=%0d want v=1 r=02 rd=3", e_out_valid, e_res, e_rd_out);
        end
`ifndef ALU_MUL_EN
        e_ctrl = MUL;
        e_sr0  = 8'h0F;
        e_sr1  = 8'h03;
        e_rd   = 5'd6;
        tick();
        total++; if (e_out_valid !== 1'b1 || e_res !== 8'h00 || e_rd_out !== 5'd6) begin
            bad++; $display("FAIL w8_mul got v=%b r=%h rd=%0d want v=1 r=00 rd=6", e_out_valid, e_res, e_rd_out);
        end
`endif
        e_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ctrl = ADD; rd_in = '0; sr0 = '0; sr1 = '0;
        e_valid = 1'b0; e_ctrl = ADD; e_rd = '0; e_sr0 = '0; e_sr1 = '0;
        test_reset();
        test_sub_slt_sra();
        test_op_table();
        test_back_pressure();
        test_flush();
`ifdef ALU_MUL_EN
        test_multiply();
        test_flush_mul();
`else
        test_mul_disabled();
`endif
        test_width8();
        issue(ADD, 32'd5, 32'd6, 5'd17);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
